// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester add/sub arbiter: FSM encoding,
// requester count and the response flag bundle.
package alu_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Result width is a module parameter, so the data word is paired with
  // this bundle inside the arbiter rather than living here.
  typedef struct packed {
    logic id;
    logic carry;
    logic zero;
    logic overflow;
  } resp_flags_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit add/subtract: a + (b ^ {sub}) + sub with
// carry, zero and signed-overflow flags.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;

  assign bx  = b ^ {WIDTH{sub}};
  assign sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};

  assign result   = sum[WIDTH-1:0];
  assign carry    = sum[WIDTH];
  assign zero     = ~|sum[WIDTH-1:0];
  // Same-sign inputs to the adder that produce an opposite-sign sum.
  assign overflow = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one add/sub datapath; round-robin grant, one-cycle
// compute, response held until accepted. ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_sub,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_id,
  output logic [WIDTH-1:0]         resp_result,
  output logic                     resp_carry,
  output logic                     resp_zero,
  output logic                     resp_overflow
);

  typedef struct packed {
    resp_flags_t      flags;
    logic [WIDTH-1:0] result;
  } resp_t;

  logic [NUM_REQ-1:0][WIDTH-1:0] a_vec, b_vec;
  state_t           state;
  resp_t            resp_q;
  logic             gnt_vld;
  logic             gnt_id;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry, alu_zero, alu_overflow;

  assign a_vec = req_a;
  assign b_vec = req_b;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic last_grant;
`endif

  always_comb begin
    gnt_vld = (state == IDLE) && (|req_valid);
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt_id = ~req_valid[0];
`else
    if (&req_valid) gnt_id = ~last_grant;
    else            gnt_id = ~req_valid[0];
`endif
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_id] = 1'b1;
  end

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (a_vec[gnt_id]),
    .b        (b_vec[gnt_id]),
    .sub      (req_sub[gnt_id]),
    .result   (alu_result),
    .carry    (alu_carry),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      resp_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          resp_q.flags.id       <= gnt_id;
          resp_q.flags.carry    <= alu_carry;
          resp_q.flags.zero     <= alu_zero;
          resp_q.flags.overflow <= alu_overflow;
          resp_q.result         <= alu_result;
          state                 <= RESP;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_grant <= gnt_id;
`endif
        end
        // No bypass: the handshake edge only returns to IDLE.
        RESP: if (resp_ready) state <= IDLE;
      endcase
    end
  end

  assign resp_valid    = (state == RESP);
  assign resp_id       = resp_q.flags.id;
  assign resp_result   = resp_q.result;
  assign resp_carry    = resp_q.flags.carry;
  assign resp_zero     = resp_q.flags.zero;
  assign resp_overflow = resp_q.flags.overflow;

  a_onehot_grant: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

  a_resp_stable: assert property (@(posedge clk)
    (resp_valid && !resp_ready && !rst) |=> (resp_valid && $stable(resp_q)));

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one WIDTH-bit add/subtract datapath between two requesters.
- Each requester uses a valid/ready handshake to present operands and an add/sub select.
- The block grants one request at a time (round-robin by default), computes the result and flags in one cycle, and holds a tagged response until the consumer accepts it.
- Sits between the instruction/test sequencers and the single adder, so the adder is never instantiated twice.

Parameters:
- WIDTH, 32, operand/result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock, the single clock domain.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  bit i: requester i presents a request.
- req_ready  output  2  bit i: request i accepted this cycle (transfer = valid & ready).
- req_sub  input  2  bit i: 0 = a+b, 1 = a-b, for requester i.
- req_a  input  2*WIDTH  operand a; requester i on bits [i*WIDTH +: WIDTH].
- req_b  input  2*WIDTH  operand b; same packing as req_a.
- resp_valid  output  1  response held on resp_* outputs.
- resp_ready  input  1  consumer accepts the response (transfer = valid & ready).
- resp_id  output  1  index of the requester that owns the response.
- resp_result  output  WIDTH  a+b or a-b, modulo 2^WIDTH.
- resp_carry  output  1  carry out of bit WIDTH-1 of a + (b XOR {WIDTH{sub}}) + sub; for subtract, 1 = no borrow.
- resp_zero  output  1  resp_result == 0.
- resp_overflow  output  1  two's-complement signed overflow of the selected operation.

Behaviour:
- FSM states: IDLE, RESP. Reset enters IDLE.
- Reset values: resp_valid=0, resp_id=0, resp_result=0, all flags=0, last_grant=1 (so requester 0 wins the first tie).
- IDLE:
  - If any req_valid bit is set, grant exactly one requester: assert its req_ready (combinational) and leave the other bit at 0.
  - Arbitration: the single valid requester wins. If both are valid, the winner is the requester that is NOT last_grant.
  - On grant: compute on the granted operands in the same cycle, register result, flags and resp_id at the clock edge, set last_grant to the winner, go to RESP.
- RESP:
  - req_ready = 00; resp_valid = 1.
  - resp_* outputs stay stable until the cycle in which resp_ready = 1; at that edge go to IDLE and clear resp_valid.
- No bypass: a new grant never occurs in the same cycle as a response handshake.
  - Maximum throughput: one operation per 2 cycles.
  - Latency: request accepted at edge N, resp_valid = 1 from edge N onward (visible in cycle N+1).
- Requesters must hold req_valid, req_sub and operands stable until accepted. Dropping valid before acceptance is allowed and simply withdraws the request.
- Arithmetic:
  - bx = b XOR {WIDTH{sub}}.
  - {carry, result} = a + bx + sub, computed at WIDTH+1 bits.
  - overflow = (a[MSB] == bx[MSB]) && (result[MSB] != a[MSB]).
  - zero = ~|result.
  - Subtracting the most negative value from any operand follows the same formula; no special case.
- Reset mid-operation: any pending response is discarded without a handshake, state returns to IDLE, last_grant returns to 1.
- resp_ready while in IDLE is ignored.
- X-free outputs after reset.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 always wins when both are valid. last_grant is neither implemented nor used.
- Undefined (default): round-robin as described in Behaviour.

Decomposition:
- Package alu_arb_pkg holds:
  - the FSM state encoding (IDLE, RESP);
  - NUM_REQ = 2;
  - a response struct/bundle definition {id, result, carry, zero, overflow}.
- One natural sub-module: alu_addsub, a purely combinational WIDTH-bit add/sub producing result, carry, zero and overflow per the arithmetic rules above. The arbiter instantiates it exactly once.

Test Plan:
- Single add: after reset, req0 valid with a=5, b=7, sub=0 → req_ready=01 that cycle; next cycle resp_valid=1, id=0, result=12, carry=0, zero=0, overflow=0.
- Subtract flags: req1 with a=3, b=3, sub=1 → result=0, zero=1, carry=1. With a=0, b=1, sub=1 → result=FFFFFFFF, carry=0, overflow=0.
- Overflow: a=7FFFFFFF, b=1 add → result=80000000, overflow=1, carry=0. a=80000000, b=1 sub → result=7FFFFFFF, overflow=1.
- Round-robin contention: both valid continuously, resp_ready tied to 1 → grant order 0,1,0,1. With ALU_ARB_FIXED_PRIO_EN defined, grant order is 0,0,0,0.
- Backpressure: resp_ready=0 for 5 cycles with req1 waiting → resp_* stable, req_ready=00 throughout; req1 is granted in the cycle after resp_ready pulses.
- Reset mid-operation: assert rst while in RESP → next cycle resp_valid=0, all outputs at reset values; a subsequent tie grants requester 0.
